control_unit: RTL and testbench

Hardwired Moore control sequencer for the bus-based CPU datapath. It drives every datapath control strobe (bus-source `*out`, register-load `*in`, ALU opcode, memory `Read`/`Write`) through a fixed fetch sequence (T0–T2) and then an opcode-specific execute sequence (T3–T7). It sits between the memory/IO boundary and `datapath`, and replaces bench-driven control of the datapath.

---
 rtl/cpu_pkg.sv | 144 ++++++++++++++
 rtl/control_decode.sv | 177 +++++++++++++++++
 rtl/control_unit.sv | 170 +++++++++++++++++
 tb/tb_control_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared opcode, ALU-code and step encodings for the bus CPU
//            control sequencer, plus the control-word type and decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes carried in IR[31:27]
    localparam logic [4:0] c_OP_LD   = 5'd0;
    localparam logic [4:0] c_OP_LDI  = 5'd1;
    localparam logic [4:0] c_OP_ST   = 5'd2;
    localparam logic [4:0] c_OP_ADD  = 5'd3;
    localparam logic [4:0] c_OP_SUB  = 5'd4;
    localparam logic [4:0] c_OP_AND  = 5'd5;
    localparam logic [4:0] c_OP_OR   = 5'd6;
    localparam logic [4:0] c_OP_SHR  = 5'd7;
    localparam logic [4:0] c_OP_SHRA = 5'd8;
    localparam logic [4:0] c_OP_SHL  = 5'd9;
    localparam logic [4:0] c_OP_ROR  = 5'd10;
    localparam logic [4:0] c_OP_ROL  = 5'd11;
    localparam logic [4:0] c_OP_ADDI = 5'd12;
    localparam logic [4:0] c_OP_ANDI = 5'd13;
    localparam logic [4:0] c_OP_ORI  = 5'd14;
    localparam logic [4:0] c_OP_MUL  = 5'd15;
    localparam logic [4:0] c_OP_DIV  = 5'd16;
    localparam logic [4:0] c_OP_NEG  = 5'd17;
    localparam logic [4:0] c_OP_NOT  = 5'd18;
    localparam logic [4:0] c_OP_BR   = 5'd19;
    localparam logic [4:0] c_OP_JR   = 5'd20;
    localparam logic [4:0] c_OP_JAL  = 5'd21;
    localparam logic [4:0] c_OP_IN   = 5'd22;
    localparam logic [4:0] c_OP_OUT  = 5'd23;
    localparam logic [4:0] c_OP_MFHI = 5'd24;
    localparam logic [4:0] c_OP_MFLO = 5'd25;
    localparam logic [4:0] c_OP_NOP  = 5'd26;
    localparam logic [4:0] c_OP_HALT = 5'd27;

    // ALU operation codes (equal to the matching opcode)
    localparam logic [4:0] c_ALU_NONE = 5'd0;
    localparam logic [4:0] c_ALU_ADD  = 5'd3;
    localparam logic [4:0] c_ALU_AND  = 5'd5;
    localparam logic [4:0] c_ALU_OR   = 5'd6;

    // Sequencer step encodings
    localparam logic [3:0] c_STEP_T0    = 4'd0;
    localparam logic [3:0] c_STEP_T1    = 4'd1;
    localparam logic [3:0] c_STEP_T2    = 4'd2;
    localparam logic [3:0] c_STEP_T3    = 4'd3;
    localparam logic [3:0] c_STEP_T4    = 4'd4;
    localparam logic [3:0] c_STEP_T5    = 4'd5;
    localparam logic [3:0] c_STEP_T6    = 4'd6;
    localparam logic [3:0] c_STEP_T7    = 4'd7;
    localparam logic [3:0] c_STEP_HALT  = 4'd14;
    localparam logic [3:0] c_STEP_RESET = 4'd15;

    // Instruction families sharing one execute sequence
    typedef enum logic [3:0] {
        c_CLS_ALU, c_CLS_UNARY, c_CLS_IMM, c_CLS_LDI,
        c_CLS_LD, c_CLS_ST, c_CLS_MULDIV, c_CLS_BR,
        c_CLS_JR, c_CLS_JAL, c_CLS_IN, c_CLS_OUT,
        c_CLS_MFHI, c_CLS_MFLO, c_CLS_NOP, c_CLS_HALT
    } op_class_t;

    // Full control word: datapath strobes plus sequencing flags
    typedef struct packed {
        logic       pc_out;
        logic       zhigh_out;
        logic       zlow_out;
        logic       hi_out;
        logic       lo_out;
        logic       inport_out;
        logic       c_out;
        logic       mdr_out;
        logic       ba_out;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       link_sel;
        logic       mar_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       hi_in;
        logic       lo_in;
        logic       zhigh_in;
        logic       zlow_in;
        logic       con_in;
        logic       outport_in;
        logic       inc_pc;
        logic       read;
        logic       write;
        logic [4:0] alu_op;
        logic       mem_step;   // step completes only on a memory handshake
        logic       seq_end;    // last step of the instruction
        logic       halt_req;   // halt instruction reached its execute step
    } ctrl_t;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        cls = c_CLS_NOP;
        case (op)
            c_OP_LD:   cls = c_CLS_LD;
            c_OP_LDI:  cls = c_CLS_LDI;
            c_OP_ST:   cls = c_CLS_ST;
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR,
            c_OP_SHRA, c_OP_SHL, c_OP_ROR, c_OP_ROL:
                       cls = c_CLS_ALU;
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI:
                       cls = c_CLS_IMM;
            c_OP_MUL, c_OP_DIV:
                       cls = c_CLS_MULDIV;
            c_OP_NEG, c_OP_NOT:
                       cls = c_CLS_UNARY;
            c_OP_BR:   cls = c_CLS_BR;
            c_OP_JR:   cls = c_CLS_JR;
            c_OP_JAL:  cls = c_CLS_JAL;
            c_OP_IN:   cls = c_CLS_IN;
            c_OP_OUT:  cls = c_CLS_OUT;
            c_OP_MFHI: cls = c_CLS_MFHI;
            c_OP_MFLO: cls = c_CLS_MFLO;
            c_OP_HALT: cls = c_CLS_HALT;
            default:   cls = c_CLS_NOP;   // nop and unused codes 28-31
        endcase
        return cls;
    endfunction

    // Immediate forms reuse the register-register ALU function
    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        logic [4:0] code;
        case (op)
            c_OP_ANDI: code = c_ALU_AND;
            c_OP_ORI:  code = c_ALU_OR;
            default:   code = c_ALU_ADD;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module   : control_decode
// Brief    : Purely combinational map {step, opcode, branch_flag} -> control
//            word. HALT/RESET and unused steps produce an all-zero word.
// Revision : 1.0 - initial release
// ============================================================================
module control_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_step,
    input  logic [4:0] i_opcode,
    input  logic       i_branch_flag,
    output ctrl_t      o_ctrl
);

    op_class_t w_cls;

    assign w_cls = classify(i_opcode);

    // Control word for the current step of the current instruction family
    always_comb begin
        o_ctrl = '0;
        case (i_step)
            c_STEP_T0: begin
                o_ctrl.pc_out  = 1'b1;
                o_ctrl.mar_in  = 1'b1;
                o_ctrl.inc_pc  = 1'b1;
                o_ctrl.zlow_in = 1'b1;
            end
            c_STEP_T1: begin
                o_ctrl.zlow_out = 1'b1;
                o_ctrl.pc_in    = 1'b1;
                o_ctrl.read     = 1'b1;
                o_ctrl.mdr_in   = 1'b1;
                o_ctrl.mem_step = 1'b1;
            end
            c_STEP_T2: begin
                o_ctrl.mdr_out = 1'b1;
                o_ctrl.ir_in   = 1'b1;
            end
            c_STEP_T3: begin
                case (w_cls)
                    c_CLS_ALU, c_CLS_IMM: begin
                        o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.y_in = 1'b1;
                    end
                    c_CLS_UNARY: begin
                        o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.zlow_in = 1'b1;
                        o_ctrl.alu_op = i_opcode;
                    end
                    c_CLS_LDI, c_CLS_LD, c_CLS_ST: begin
                        o_ctrl.grb = 1'b1; o_ctrl.ba_out = 1'b1; o_ctrl.y_in = 1'b1;
                    end
                    c_CLS_MULDIV: begin
                        o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.y_in = 1'b1;
                    end
                    c_CLS_BR: begin
                        o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.con_in = 1'b1;
                    end
                    c_CLS_JR: begin
                        o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.pc_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    c_CLS_JAL: begin
                        o_ctrl.pc_out = 1'b1; o_ctrl.link_sel = 1'b1; o_ctrl.r_in = 1'b1;
                    end
                    c_CLS_IN: begin
                        o_ctrl.inport_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    c_CLS_OUT: begin
                        o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.outport_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    c_CLS_MFHI: begin
                        o_ctrl.hi_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    c_CLS_MFLO: begin
                        o_ctrl.lo_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    c_CLS_HALT: o_ctrl.halt_req = 1'b1;
                    default:    o_ctrl.seq_end  = 1'b1;
                endcase
            end
            c_STEP_T4: begin
                case (w_cls)
                    c_CLS_ALU: begin
                        o_ctrl.grc = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.zlow_in = 1'b1;
                        o_ctrl.alu_op = i_opcode;
                    end
                    c_CLS_UNARY: begin
                        o_ctrl.zlow_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    c_CLS_IMM: begin
                        o_ctrl.c_out = 1'b1; o_ctrl.zlow_in = 1'b1;
                        o_ctrl.alu_op = imm_alu(i_opcode);
                    end
                    c_CLS_LDI, c_CLS_LD, c_CLS_ST: begin
                        o_ctrl.c_out = 1'b1; o_ctrl.zlow_in = 1'b1;
                        o_ctrl.alu_op = c_ALU_ADD;
                    end
                    c_CLS_MULDIV: begin
                        o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1;
                        o_ctrl.zlow_in = 1'b1; o_ctrl.zhigh_in = 1'b1;
                        o_ctrl.alu_op = i_opcode;
                    end
                    c_CLS_BR: begin
                        o_ctrl.pc_out = 1'b1; o_ctrl.y_in = 1'b1;
                    end
                    c_CLS_JAL: begin
                        o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.pc_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    default: o_ctrl.seq_end = 1'b1;
                endcase
            end
            c_STEP_T5: begin
                case (w_cls)
                    c_CLS_ALU, c_CLS_IMM, c_CLS_LDI: begin
                        o_ctrl.zlow_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    c_CLS_LD, c_CLS_ST: begin
                        o_ctrl.zlow_out = 1'b1; o_ctrl.mar_in = 1'b1;
                    end
                    c_CLS_MULDIV: begin
                        o_ctrl.zlow_out = 1'b1; o_ctrl.lo_in = 1'b1;
                    end
                    c_CLS_BR: begin
                        o_ctrl.c_out = 1'b1; o_ctrl.zlow_in = 1'b1;
                        o_ctrl.alu_op = c_ALU_ADD;
                    end
                    default: o_ctrl.seq_end = 1'b1;
                endcase
            end
            c_STEP_T6: begin
                case (w_cls)
                    c_CLS_LD: begin
                        o_ctrl.read = 1'b1; o_ctrl.mdr_in = 1'b1; o_ctrl.mem_step = 1'b1;
                    end
                    c_CLS_ST: begin
                        o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.mdr_in = 1'b1;
                    end
                    c_CLS_MULDIV: begin
                        o_ctrl.zhigh_out = 1'b1; o_ctrl.hi_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    c_CLS_BR: begin
                        // Taken branch loads the computed target into PC
                        o_ctrl.zlow_out = 1'b1; o_ctrl.pc_in = i_branch_flag;
                        o_ctrl.seq_end = 1'b1;
                    end
                    default: o_ctrl.seq_end = 1'b1;
                endcase
            end
            c_STEP_T7: begin
                case (w_cls)
                    c_CLS_LD: begin
                        o_ctrl.mdr_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    c_CLS_ST: begin
                        o_ctrl.write = 1'b1; o_ctrl.mem_step = 1'b1;
                        o_ctrl.seq_end = 1'b1;
                    end
                    default: o_ctrl.seq_end = 1'b1;
                endcase
            end
            default: ;  // HALT, RESET: everything idle
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Hardwired Moore control sequencer for the bus CPU datapath.
//            Fetch T0-T2, opcode-specific execute T3-T7, HALT and RESET states.
//            Optional memory wait/timeout support under `CU_MEM_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
)(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        branch_flag,
    input  logic        Stop,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        ZHighout,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        MDRout,
    output logic        BAout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        link_sel,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHighIn,
    output logic        ZLowIn,
    output logic        CONin,
    output logic        OutPortin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run,
    output logic [3:0]  step,
    output logic        mem_timeout
);

    logic [3:0] r_step;
    logic [3:0] w_step_nxt;
    ctrl_t      w_ctrl;
    logic       w_mem_hold;     // memory step still waiting for completion
    logic       w_mem_expire;   // wait budget exhausted on this edge
    logic       w_unused;

    control_decode u_decode (
        .i_step        (r_step),
        .i_opcode      (IR[31:27]),
        .i_branch_flag (branch_flag),
        .o_ctrl        (w_ctrl)
    );

`ifdef CU_MEM_WAIT_EN
    localparam int c_WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
    logic                r_mem_timeout;

    assign w_mem_hold   = w_ctrl.mem_step & ~mem_ready;
    assign w_mem_expire = w_mem_hold & (r_wait_cnt == c_WAIT_W'(MEM_WAIT_MAX - 1));
    assign w_wait_cnt_nxt = (w_mem_hold && !w_mem_expire) ? r_wait_cnt + 1'b1 : '0;

    // Wait-cycle counter and sticky timeout flag
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_mem_expire) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign w_unused    = &{1'b0, IR[26:0]};
`else
    // Memory steps always complete in a single clock
    assign w_mem_hold   = 1'b0;
    assign w_mem_expire = 1'b0;
    assign mem_timeout  = 1'b0;
    assign w_unused     = &{1'b0, IR[26:0], mem_ready, (MEM_WAIT_MAX != 0)};
`endif

    // Step register; Clear forces RESET immediately
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_step <= c_STEP_RESET;
        end else begin
            r_step <= w_step_nxt;
        end
    end

    // Next step: advance, hold on memory wait, return to T0 or halt
    always_comb begin
        w_step_nxt = r_step;
        case (r_step)
            c_STEP_RESET: w_step_nxt = Stop ? c_STEP_HALT : c_STEP_T0;
            c_STEP_HALT:  w_step_nxt = c_STEP_HALT;
            default: begin
                if (w_ctrl.halt_req || w_mem_expire) begin
                    w_step_nxt = c_STEP_HALT;
                end else if (w_mem_hold) begin
                    w_step_nxt = r_step;
                end else if (w_ctrl.seq_end) begin
                    // Stop is honoured only between instructions
                    w_step_nxt = Stop ? c_STEP_HALT : c_STEP_T0;
                end else begin
                    w_step_nxt = r_step + 4'd1;
                end
            end
        endcase
    end

    // Moore outputs straight from the decoded control word
    always_comb begin
        PCout     = w_ctrl.pc_out;
        ZHighout  = w_ctrl.zhigh_out;
        Zlowout   = w_ctrl.zlow_out;
        HIout     = w_ctrl.hi_out;
        LOout     = w_ctrl.lo_out;
        InPortout = w_ctrl.inport_out;
        Cout      = w_ctrl.c_out;
        MDRout    = w_ctrl.mdr_out;
        BAout     = w_ctrl.ba_out;
        Gra       = w_ctrl.gra;
        Grb       = w_ctrl.grb;
        Grc       = w_ctrl.grc;
        Rin       = w_ctrl.r_in;
        Rout      = w_ctrl.r_out;
        link_sel  = w_ctrl.link_sel;
        MARin     = w_ctrl.mar_in;
        PCin      = w_ctrl.pc_in;
        MDRin     = w_ctrl.mdr_in;
        IRin      = w_ctrl.ir_in;
        Yin       = w_ctrl.y_in;
        HIin      = w_ctrl.hi_in;
        LOin      = w_ctrl.lo_in;
        ZHighIn   = w_ctrl.zhigh_in;
        ZLowIn    = w_ctrl.zlow_in;
        CONin     = w_ctrl.con_in;
        OutPortin = w_ctrl.outport_in;
        IncPC     = w_ctrl.inc_pc;
        Read      = w_ctrl.read;
        Write     = w_ctrl.write;
        alu_op    = w_ctrl.alu_op;
        Run       = (r_step <= c_STEP_T7);
        step      = r_step;
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Self-checking bench for control_unit: table of per-cycle vectors
//            plus hand sequences for halt, async clear and memory waits.
//            Wait/timeout sequences follow `CU_MEM_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic [31:0] IR = '0;
    logic        branch_flag = 1'b0;
    logic        Stop = 1'b0;
    logic        mem_ready = 1'b1;
    logic PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout, BAout;
    logic Gra, Grb, Grc, Rin, Rout, link_sel;
    logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, CONin, OutPortin;
    logic IncPC, Read, Write, Run, mem_timeout;
    logic [4:0] alu_op;
    logic [3:0] step;

    control_unit #(.MEM_WAIT_MAX(15)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .branch_flag(branch_flag),
        .Stop(Stop), .mem_ready(mem_ready),
        .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .HIout(HIout),
        .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .MDRout(MDRout),
        .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .link_sel(link_sel), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn),
        .ZLowIn(ZLowIn), .CONin(CONin), .OutPortin(OutPortin), .IncPC(IncPC),
        .Read(Read), .Write(Write), .alu_op(alu_op), .Run(Run), .step(step),
        .mem_timeout(mem_timeout)
    );

    always #5 Clock = ~Clock;

    // Strobe bit positions in the observed vector
    localparam logic [28:0] c_PCOUT = 29'h1 << 28, c_ZHOUT = 29'h1 << 27, c_ZLOUT = 29'h1 << 26;
    localparam logic [28:0] c_HIOUT = 29'h1 << 25, c_LOOUT = 29'h1 << 24, c_INPOUT = 29'h1 << 23;
    localparam logic [28:0] c_COUT  = 29'h1 << 22, c_MDROUT = 29'h1 << 21, c_BAOUT = 29'h1 << 20;
    localparam logic [28:0] c_GRA   = 29'h1 << 19, c_GRB = 29'h1 << 18, c_GRC = 29'h1 << 17;
    localparam logic [28:0] c_RIN   = 29'h1 << 16, c_ROUT = 29'h1 << 15, c_LINK = 29'h1 << 14;
    localparam logic [28:0] c_MARIN = 29'h1 << 13, c_PCIN = 29'h1 << 12, c_MDRIN = 29'h1 << 11;
    localparam logic [28:0] c_IRIN  = 29'h1 << 10, c_YIN = 29'h1 << 9, c_HIIN = 29'h1 << 8;
    localparam logic [28:0] c_LOIN  = 29'h1 << 7, c_ZHIN = 29'h1 << 6, c_ZLIN = 29'h1 << 5;
    localparam logic [28:0] c_CONIN = 29'h1 << 4, c_OUTPIN = 29'h1 << 3, c_INCPC = 29'h1 << 2;
    localparam logic [28:0] c_READ  = 29'h1 << 1, c_WRITE = 29'h1;
    localparam logic [28:0] c_NONE  = 29'h0;
    localparam logic [28:0] c_F0 = c_PCOUT | c_MARIN | c_INCPC | c_ZLIN;
    localparam logic [28:0] c_F1 = c_ZLOUT | c_PCIN | c_READ | c_MDRIN;
    localparam logic [28:0] c_F2 = c_MDROUT | c_IRIN;

    logic [28:0] w_obs;
    assign w_obs = {PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout, BAout,
                    Gra, Grb, Grc, Rin, Rout, link_sel, MARin, PCin, MDRin, IRin, Yin,
                    HIin, LOin, ZHighIn, ZLowIn, CONin, OutPortin, IncPC, Read, Write};

    typedef struct {
        logic [4:0]  op;
        logic        bflag;
        logic        stop;
        logic [3:0]  exp_step;
        logic [28:0] exp_ctrl;
        logic [4:0]  exp_alu;
        logic        exp_run;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [3:0] s, input logic [28:0] c,
                         input logic [4:0] a, input logic run_e, input logic to_e);
        n_tests++;
        if (step !== s || w_obs !== c || alu_op !== a || Run !== run_e || mem_timeout !== to_e) begin
            n_fail++;
            $display("FAIL %s: got step=%0d ctrl=%h alu=%0d run=%b to=%b, want step=%0d ctrl=%h alu=%0d run=%b to=%b",
                     name, step, w_obs, alu_op, Run, mem_timeout, s, c, a, run_e, to_e);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic add(input logic [4:0] op, input logic bf, input logic st,
                       input logic [3:0] s, input logic [28:0] c, input logic [4:0] a);
        vec_t v;
        v.op = op; v.bflag = bf; v.stop = st;
        v.exp_step = s; v.exp_ctrl = c; v.exp_alu = a; v.exp_run = (s <= 4'd7);
        vq.push_back(v);
    endtask

    task automatic add_fetch(input logic [4:0] op, input logic bf);
        add(op, bf, 1'b0, 4'd0, c_F0, 5'd0);
        add(op, bf, 1'b0, 4'd1, c_F1, 5'd0);
        add(op, bf, 1'b0, 4'd2, c_F2, 5'd0);
    endtask

    task automatic run_vectors(input string tag);
        foreach (vq[i]) begin
            IR          = {vq[i].op, 4'd5, 4'd2, 4'd4, 15'd0};
            branch_flag = vq[i].bflag;
            Stop        = vq[i].stop;
            mem_ready   = 1'b1;
            #1;
            check($sformatf("%s_vec%0d", tag, i), vq[i].exp_step, vq[i].exp_ctrl,
                  vq[i].exp_alu, vq[i].exp_run, 1'b0);
            tick();
        end
        vq.delete();
    endtask

    // Assert Clear, check the RESET state, release; ends at posedge+1 in T0
    task automatic do_reset();
        Stop = 1'b0; mem_ready = 1'b1; branch_flag = 1'b0;
        Clear = 1'b0;
        #2;
        check("reset_async", 4'd15, c_NONE, 5'd0, 1'b0, 1'b0);
        tick();
        check("reset_held", 4'd15, c_NONE, 5'd0, 1'b0, 1'b0);
        Clear = 1'b1;
        #1;
        check("reset_release_no_edge", 4'd15, c_NONE, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #1;
        do_reset();

        // sub r5,r2,r4
        add_fetch(5'd4, 1'b0);
        add(5'd4, 0, 0, 4'd3, c_GRB | c_ROUT | c_YIN, 5'd0);
        add(5'd4, 0, 0, 4'd4, c_GRC | c_ROUT | c_ZLIN, 5'd4);
        add(5'd4, 0, 0, 4'd5, c_ZLOUT | c_GRA | c_RIN, 5'd0);
        // br not taken, then taken
        for (int f = 0; f < 2; f++) begin
            add_fetch(5'd19, f[0]);
            add(5'd19, f[0], 0, 4'd3, c_GRA | c_ROUT | c_CONIN, 5'd0);
            add(5'd19, f[0], 0, 4'd4, c_PCOUT | c_YIN, 5'd0);
            add(5'd19, f[0], 0, 4'd5, c_COUT | c_ZLIN, 5'd3);
            add(5'd19, f[0], 0, 4'd6, f[0] ? (c_ZLOUT | c_PCIN) : c_ZLOUT, 5'd0);
        end
        // ld
        add_fetch(5'd0, 1'b0);
        add(5'd0, 0, 0, 4'd3, c_GRB | c_BAOUT | c_YIN, 5'd0);
        add(5'd0, 0, 0, 4'd4, c_COUT | c_ZLIN, 5'd3);
        add(5'd0, 0, 0, 4'd5, c_ZLOUT | c_MARIN, 5'd0);
        add(5'd0, 0, 0, 4'd6, c_READ | c_MDRIN, 5'd0);
        add(5'd0, 0, 0, 4'd7, c_MDROUT | c_GRA | c_RIN, 5'd0);
        // st
        add_fetch(5'd2, 1'b0);
        add(5'd2, 0, 0, 4'd3, c_GRB | c_BAOUT | c_YIN, 5'd0);
        add(5'd2, 0, 0, 4'd4, c_COUT | c_ZLIN, 5'd3);
        add(5'd2, 0, 0, 4'd5, c_ZLOUT | c_MARIN, 5'd0);
        add(5'd2, 0, 0, 4'd6, c_GRA | c_ROUT | c_MDRIN, 5'd0);
        add(5'd2, 0, 0, 4'd7, c_WRITE, 5'd0);
        // ldi
        add_fetch(5'd1, 1'b0);
        add(5'd1, 0, 0, 4'd3, c_GRB | c_BAOUT | c_YIN, 5'd0);
        add(5'd1, 0, 0, 4'd4, c_COUT | c_ZLIN, 5'd3);
        add(5'd1, 0, 0, 4'd5, c_ZLOUT | c_GRA | c_RIN, 5'd0);
        // ori -> or
        add_fetch(5'd14, 1'b0);
        add(5'd14, 0, 0, 4'd3, c_GRB | c_ROUT | c_YIN, 5'd0);
        add(5'd14, 0, 0, 4'd4, c_COUT | c_ZLIN, 5'd6);
        add(5'd14, 0, 0, 4'd5, c_ZLOUT | c_GRA | c_RIN, 5'd0);
        // shra
        add_fetch(5'd8, 1'b0);
        add(5'd8, 0, 0, 4'd3, c_GRB | c_ROUT | c_YIN, 5'd0);
        add(5'd8, 0, 0, 4'd4, c_GRC | c_ROUT | c_ZLIN, 5'd8);
        add(5'd8, 0, 0, 4'd5, c_ZLOUT | c_GRA | c_RIN, 5'd0);
        // neg
        add_fetch(5'd17, 1'b0);
        add(5'd17, 0, 0, 4'd3, c_GRB | c_ROUT | c_ZLIN, 5'd17);
        add(5'd17, 0, 0, 4'd4, c_ZLOUT | c_GRA | c_RIN, 5'd0);
        // jr, jal
        add_fetch(5'd20, 1'b0);
        add(5'd20, 0, 0, 4'd3, c_GRA | c_ROUT | c_PCIN, 5'd0);
        add_fetch(5'd21, 1'b0);
        add(5'd21, 0, 0, 4'd3, c_PCOUT | c_LINK | c_RIN, 5'd0);
        add(5'd21, 0, 0, 4'd4, c_GRA | c_ROUT | c_PCIN, 5'd0);
        // in, out, mfhi, mflo, nop, unused code 30
        add_fetch(5'd22, 1'b0);
        add(5'd22, 0, 0, 4'd3, c_INPOUT | c_GRA | c_RIN, 5'd0);
        add_fetch(5'd23, 1'b0);
        add(5'd23, 0, 0, 4'd3, c_GRA | c_ROUT | c_OUTPIN, 5'd0);
        add_fetch(5'd24, 1'b0);
        add(5'd24, 0, 0, 4'd3, c_HIOUT | c_GRA | c_RIN, 5'd0);
        add_fetch(5'd25, 1'b0);
        add(5'd25, 0, 0, 4'd3, c_LOOUT | c_GRA | c_RIN, 5'd0);
        add_fetch(5'd26, 1'b0);
        add(5'd26, 0, 0, 4'd3, c_NONE, 5'd0);
        add_fetch(5'd30, 1'b0);
        add(5'd30, 0, 0, 4'd3, c_NONE, 5'd0);
        // mul with Stop raised mid-instruction: completes, then HALT
        add_fetch(5'd15, 1'b0);
        add(5'd15, 0, 0, 4'd3, c_GRA | c_ROUT | c_YIN, 5'd0);
        add(5'd15, 0, 1, 4'd4, c_GRB | c_ROUT | c_ZLIN | c_ZHIN, 5'd15);
        add(5'd15, 0, 1, 4'd5, c_ZLOUT | c_LOIN, 5'd0);
        add(5'd15, 0, 1, 4'd6, c_ZHOUT | c_HIIN, 5'd0);
        add(5'd15, 0, 1, 4'd14, c_NONE, 5'd0);
        add(5'd15, 0, 0, 4'd14, c_NONE, 5'd0);
        run_vectors("main");

        // halt instruction
        do_reset();
        add_fetch(5'd27, 1'b0);
        add(5'd27, 0, 0, 4'd3, c_NONE, 5'd0);
        add(5'd27, 0, 0, 4'd14, c_NONE, 5'd0);
        add(5'd26, 0, 0, 4'd14, c_NONE, 5'd0);
        run_vectors("halt");

        // Clear asserted in the middle of st T6
        do_reset();
        add_fetch(5'd2, 1'b0);
        add(5'd2, 0, 0, 4'd3, c_GRB | c_BAOUT | c_YIN, 5'd0);
        add(5'd2, 0, 0, 4'd4, c_COUT | c_ZLIN, 5'd3);
        add(5'd2, 0, 0, 4'd5, c_ZLOUT | c_MARIN, 5'd0);
        run_vectors("st");
        check("st_T6", 4'd6, c_GRA | c_ROUT | c_MDRIN, 5'd0, 1'b1, 1'b0);
        #2 Clear = 1'b0;
        #1 check("clear_mid_st", 4'd15, c_NONE, 5'd0, 1'b0, 1'b0);
        #2 Clear = 1'b1;
        #1 check("clear_released", 4'd15, c_NONE, 5'd0, 1'b0, 1'b0);
        tick();
        check("after_clear_T0", 4'd0, c_F0, 5'd0, 1'b1, 1'b0);

        // ld whose T6 sees mem_ready low for three cycles
        do_reset();
        add_fetch(5'd0, 1'b0);
        add(5'd0, 0, 0, 4'd3, c_GRB | c_BAOUT | c_YIN, 5'd0);
        add(5'd0, 0, 0, 4'd4, c_COUT | c_ZLIN, 5'd3);
        add(5'd0, 0, 0, 4'd5, c_ZLOUT | c_MARIN, 5'd0);
        run_vectors("ldw");
        mem_ready = 1'b0;
`ifdef CU_MEM_WAIT_EN
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ld_T6_wait%0d", k), 4'd6, c_READ | c_MDRIN, 5'd0, 1'b1, 1'b0);
            tick();
        end
        mem_ready = 1'b1;
        check("ld_T6_ready", 4'd6, c_READ | c_MDRIN, 5'd0, 1'b1, 1'b0);
        tick();
        check("ld_T7", 4'd7, c_MDROUT | c_GRA | c_RIN, 5'd0, 1'b1, 1'b0);
        tick();
        check("ld_back_T0", 4'd0, c_F0, 5'd0, 1'b1, 1'b0);
        // Fetch read never completes: timeout after 15 wait cycles
        mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 15; k++) begin
            check($sformatf("T1_wait%0d", k), 4'd1, c_F1, 5'd0, 1'b1, 1'b0);
            tick();
        end
        check("timeout_halt", 4'd14, c_NONE, 5'd0, 1'b0, 1'b1);
        mem_ready = 1'b1;
        tick();
        check("timeout_sticky", 4'd14, c_NONE, 5'd0, 1'b0, 1'b1);
        do_reset();
        check("timeout_cleared_T0", 4'd0, c_F0, 5'd0, 1'b1, 1'b0);
`else
        check("ld_T6_noready", 4'd6, c_READ | c_MDRIN, 5'd0, 1'b1, 1'b0);
        tick();
        check("ld_T7_single_clock", 4'd7, c_MDROUT | c_GRA | c_RIN, 5'd0, 1'b1, 1'b0);
        tick();
        check("ld_back_T0", 4'd0, c_F0, 5'd0, 1'b1, 1'b0);
        tick();
        check("T1_noready", 4'd1, c_F1, 5'd0, 1'b1, 1'b0);
        tick();
        check("T2_after_T1", 4'd2, c_F2, 5'd0, 1'b1, 1'b0);
        mem_ready = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
